axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
- AXI4 master engine that converts one user command (read or write, address, burst length) into a complete AXI4 INCR burst transaction, then reports completion status.
- Sits between a local request source (test sequencer or DMA-style client) and an AXI4 slave/interconnect.
- Serves one transaction at a time; no outstanding-transaction overlap.

Parameters:
- ADDR_W, 32, address width (awaddr/araddr/cmd_addr).
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- LEN_W, 8, burst length field width (AXI4 awlen/arlen; beats = len+1).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  start byte address.
- cmd_len  in  LEN_W  beats-1.
- usr_wdata  in  DATA_W  write beat data.
- usr_wstrb  in  DATA_W/8  write beat strobes.
- usr_wvalid  in  1  write beat available.
- usr_wready  out  1  beat consumed; equals wready & wvalid.
- rd_data  out  DATA_W  read beat data.
- rd_valid  out  1  one-cycle pulse per read beat.
- rd_last  out  1  marks final read beat.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 if any bresp/rresp != OKAY.
- awaddr  out  ADDR_W
- awlen  out  LEN_W
- awvalid  out  1
- awready  in  1
- wdata  out  DATA_W
- wstrb  out  DATA_W/8
- wlast  out  1
- wvalid  out  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1
- araddr  out  ADDR_W
- arlen  out  LEN_W
- arvalid  out  1
- arready  in  1
- rdata  in  DATA_W
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1

Behaviour:
- Reset (async assert, sync deassert): state IDLE; every output 0 except cmd_ready=1 in IDLE; beat counter 0; err 0. Reset mid-burst aborts immediately, with no completion pulse.
- Fixed burst attributes (not ported): INCR, size = log2(DATA_W/8).
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: on cmd_valid, latch addr/len/write, clear counter and err. Next state is WR_ADDR or RD_ADDR.
- WR_ADDR: awvalid=1 with latched awaddr/awlen, held stable until awready. Go to WR_DATA the cycle after the handshake.
- WR_DATA: wvalid = usr_wvalid; wdata/wstrb pass through combinationally. A beat transfers on wvalid & wready, and the counter then increments. wlast=1 when counter == len. Once the last beat transfers, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, err |= (bresp != 0), then go to DONE.
- RD_ADDR: arvalid=1 held until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid: rd_data <= rdata, rd_valid pulse, err |= (rresp != 0). Beat counter counts.
  - Burst ends on rlast or counter == len, whichever comes first.
  - If these disagree, rlast wins and err is set.
  - Then go to DONE.
- DONE: done=1 for one cycle, err held while done=1, then return to IDLE. Latency from command accept to done, assuming zero-wait slave, is (len+1)+4 cycles for a write.
- No combinational path from any AXI *ready input to the same channel's valid output.
- len=0 is a single beat: wlast is asserted on the first beat.
- len = max (255) runs to completion; the counter is LEN_W+1 wide so it cannot wrap.
- cmd_valid while busy is ignored, because cmd_ready=0.
- Simultaneous valid/ready in the same cycle as state entry is allowed.

Test Plan:
- Reset: rst high mid-way through a len=3 write -> all AXI valids go 0 asynchronously, cmd_ready=1 after release, no done pulse.
- Single write: addr 0x1000, len 0, data 0xDEADBEEF, strb 0xF, slave always ready, bresp OKAY.
  - awaddr=0x1000, awlen=0.
  - One W beat with wlast=1.
  - done=1, err=0.
- Single read: addr 0x2000, len 0, slave returns 0xCAFEF00D with rlast.
  - rd_valid pulse with rd_data=0xCAFEF00D, rd_last=1.
  - done=1, err=0.
- Burst write: addr 0x3000, len 3, data 1..4, wready toggling every other cycle.
  - Exactly 4 beats in order.
  - wlast only on beat 4.
  - Data stable while wvalid & !wready.
- Burst read with error: addr 0x4000, len 7, slave returns SLVERR (rresp=2) on beat 5 -> 8 rd_valid pulses, done=1, err=1.
- Back-to-back: write len 1 followed immediately by read len 1 to the same address, cmd_valid held high.
  - Second command accepted in the IDLE cycle after done.
  - No overlap of AW and AR activity.

Source files
------------

// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one read/write command into a single AXI4 INCR burst
// and reports completion with a one-cycle done pulse and an error flag.
`default_nettype none

module axi_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_W-1:0]   usr_wdata,
    input  logic [DATA_W/8-1:0] usr_wstrb,
    input  logic                usr_wvalid,
    output logic                usr_wready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_last,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [LEN_W-1:0]    awlen,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [LEN_W-1:0]    arlen,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t             state;
    logic [LEN_W:0]     cnt;
    logic [LEN_W-1:0]   len_q;
    logic               last_beat;
    logic               in_wdata;

    // One bit wider than the length field so a 256-beat burst cannot wrap.
    assign last_beat  = (cnt == {1'b0, len_q});
    assign in_wdata   = (state == WR_DATA);

    assign wvalid     = in_wdata & usr_wvalid;
    assign wdata      = in_wdata ? usr_wdata : '0;
    assign wstrb      = in_wdata ? usr_wstrb : '0;
    assign wlast      = in_wdata & last_beat;
    assign usr_wready = wvalid & wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            cnt       <= '0;
            len_q     <= '0;
            awaddr    <= '0;
            awlen     <= '0;
            awvalid   <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cnt       <= '0;
                        err       <= 1'b0;
                        len_q     <= cmd_len;
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            awlen   <= cmd_len;
                            awvalid <= 1'b1;
                            state   <= WR_ADDR;
                        end else begin
                            araddr  <= cmd_addr;
                            arlen   <= cmd_len;
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (usr_wvalid && wready) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            bready <= 1'b1;
                            state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        err    <= err | (bresp != 2'b00);
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rd_data  <= rdata;
                        rd_valid <= 1'b1;
                        cnt      <= cnt + 1'b1;
                        // Slave's rlast ends the burst; disagreement with our count is an error.
                        if (rlast || last_beat) begin
                            rd_last <= 1'b1;
                            rready  <= 1'b0;
                            done    <= 1'b1;
                            err     <= err | (rresp != 2'b00) | (rlast != last_beat);
                            state   <= DONE;
                        end else begin
                            err     <= err | (rresp != 2'b00);
                        end
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed vector table plus randomized transactions for
// axi_burst_master, with a transaction-level reference model and slave model.
`default_nettype none

module tb_axi_burst_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] usr_wdata;
    logic [SW-1:0] usr_wstrb;
    logic          usr_wvalid, usr_wready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_last, done, err;
    logic [AW-1:0] awaddr, araddr;
    logic [LW-1:0] awlen, arlen;
    logic          awvalid, awready, wlast, wvalid, wready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rlast, rvalid, rready;

    axi_burst_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wvalid(usr_wvalid),
        .usr_wready(usr_wready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .err(err),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rl_mode: -1 rlast on final beat, -2 rlast never asserted, k>=0 rlast on beat k.
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          len;
        int          wmode;
        int          err_beat;
        logic [1:0]  bresp;
        int          rl_mode;
        bit          b2b;
        logic [31:0] base;
        int          exp_beats;
        bit          exp_err;
    } vec_t;

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit early;
        if (v.wr) begin
            r.exp_beats = v.len + 1;
            r.exp_err   = (v.bresp != 2'b00);
        end else begin
            early       = (v.rl_mode >= 0) && (v.rl_mode < v.len);
            r.exp_beats = early ? v.rl_mode + 1 : v.len + 1;
            r.exp_err   = early || (v.rl_mode == -2) ||
                          (v.err_beat >= 0 && v.err_beat < r.exp_beats);
        end
        return r;
    endfunction

    task automatic idle_inputs(input bit keep_cmd);
        if (!keep_cmd) cmd_valid = 1'b0;
        usr_wvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; bresp = 2'b00; rresp = 2'b00;
    endtask

    task automatic run_txn(input vec_t v, input bit expect_imm);
        int cyc = 0, acc = -1, wb = 0, rb = 0, rd_cnt = 0, stop;
        bit accepted = 0, ar_done = 0, b_done = 0, fin = 0, stall = 0, hold = 0, ovl = 0;
        logic [31:0] prev_wd = '0;
        logic [3:0]  ws[256];
        stop = ((v.rl_mode >= 0) && (v.rl_mode < v.len)) ? v.rl_mode + 1 : v.len + 1;
        for (int i = 0; i < 256; i++) ws[i] = (v.wmode == 2) ? 4'($urandom) : 4'hF;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            if (!accepted) begin
                cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = LW'(v.len);
            end else begin
                cmd_valid = v.b2b;
            end
            if (v.wr && accepted && wb <= v.len) begin
                usr_wvalid = hold ? 1'b1 : ((v.wmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1);
                usr_wdata  = v.base + wb;
                usr_wstrb  = ws[wb];
            end else begin
                usr_wvalid = 1'b0;
            end
            awready = (v.wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            arready = (v.wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = (v.wmode == 1) ? cyc[0] : (v.wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            bvalid  = v.wr && (wb == v.len + 1) && !b_done &&
                      ((v.wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
            bresp   = v.bresp;
            rvalid  = ar_done && (rb < stop) && ((v.wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
            rdata   = v.base + rb;
            rresp   = (rb == v.err_beat) ? 2'b10 : 2'b00;
            rlast   = (v.rl_mode == -2) ? 1'b0 : (rb == stop - 1);
            #1;
            if (!accepted && cmd_valid && cmd_ready) begin
                accepted = 1; acc = cyc;
            end
            if (v.wr && (arvalid || rready)) ovl = 1;
            if (!v.wr && (awvalid || wvalid || bready)) ovl = 1;
            if (awvalid && awready) begin
                chk("awaddr", awaddr, v.addr);
                chk("awlen", awlen, 64'(v.len));
            end
            if (arvalid && arready) begin
                chk("araddr", araddr, v.addr);
                chk("arlen", arlen, 64'(v.len));
                ar_done = 1;
            end
            if (stall) chk("w_hold", {wvalid, wdata}, {1'b1, prev_wd});
            if (wvalid && wready) begin
                chk("wdata", wdata, v.base + wb);
                chk("wstrb", wstrb, ws[wb]);
                chk("wlast", wlast, (wb == v.len));
                chk("usr_wready", usr_wready, 1);
                wb++;
            end
            stall   = wvalid && !wready;
            prev_wd = wdata;
            hold    = usr_wvalid && !usr_wready;
            if (bvalid && bready) b_done = 1;
            if (rvalid && rready) rb++;
            if (rd_valid) begin
                chk("rd_data", rd_data, v.base + rd_cnt);
                chk("rd_last", rd_last, (rd_cnt == v.exp_beats - 1));
                rd_cnt++;
            end
            if (done) begin
                fin = 1;
                chk("done_err", err, v.exp_err);
                chk("beats", v.wr ? wb : rd_cnt, v.exp_beats);
                chk("no_overlap", ovl, 0);
                if (v.wr && v.wmode == 0) chk("latency", cyc - acc + 1, v.len + 5);
                if (expect_imm) chk("b2b_accept_cycle", acc, 0);
            end
            cyc++;
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL txn_timeout: got no done, required done within 3000 cycles");
        end
        idle_inputs(v.b2b);
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        int saw;
        bit prev_b2b;
        tbl[0]  = '{1'b1, 32'h1000, 0,   0, -1, 2'b00, -1, 1'b0, 32'hDEADBEEF, 1,   1'b0};
        tbl[1]  = '{1'b0, 32'h2000, 0,   0, -1, 2'b00, -1, 1'b0, 32'hCAFEF00D, 1,   1'b0};
        tbl[2]  = '{1'b1, 32'h3000, 3,   1, -1, 2'b00, -1, 1'b0, 32'h1,        4,   1'b0};
        tbl[3]  = '{1'b0, 32'h4000, 7,   0,  4, 2'b00, -1, 1'b0, 32'h400,      8,   1'b1};
        tbl[4]  = '{1'b1, 32'h5000, 1,   0, -1, 2'b00, -1, 1'b1, 32'h10,       2,   1'b0};
        tbl[5]  = '{1'b0, 32'h5000, 1,   0, -1, 2'b00, -1, 1'b0, 32'h20,       2,   1'b0};
        tbl[6]  = '{1'b1, 32'h6000, 255, 0, -1, 2'b00, -1, 1'b0, 32'h100,      256, 1'b0};
        tbl[7]  = '{1'b1, 32'h7000, 2,   0, -1, 2'b10, -1, 1'b0, 32'h55,       3,   1'b1};
        tbl[8]  = '{1'b0, 32'h8000, 5,   0, -1, 2'b00,  2, 1'b0, 32'h77,       3,   1'b1};
        tbl[9]  = '{1'b0, 32'h9000, 3,   0, -1, 2'b00, -2, 1'b0, 32'h88,       4,   1'b1};
        tbl[10] = '{1'b0, 32'hA000, 255, 0, -1, 2'b00, -1, 1'b0, 32'h900,      256, 1'b0};

        rst = 1'b1; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        usr_wdata = '0; usr_wstrb = '0; rdata = '0;
        idle_inputs(1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {awvalid, wvalid, wlast, bready, arvalid, rready, done, rd_valid,
                              rd_last, err, usr_wready}, 0);
        chk("reset_addr", {awaddr, araddr}, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        prev_b2b = 0;
        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i], prev_b2b);
            prev_b2b = tbl[i].b2b;
        end

        // Reset asserted between clock edges in the middle of a len=3 write.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hB000; cmd_len = 8'd3;
        awready = 1'b1; wready = 1'b1; usr_wvalid = 1'b1; usr_wdata = 32'h1234; usr_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_rst_wvalid", wvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs", {awvalid, wvalid, bready, arvalid, rready, done, rd_valid, err}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        idle_inputs(1'b0);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done) saw++;
        end
        chk("rst_no_done", saw, 0);
        chk("rst_cmd_ready_after", cmd_ready, 1);

        for (int n = 0; n < 24; n++) begin
            int r;
            rv.wr       = 1'($urandom_range(0, 1));
            rv.addr     = $urandom & 32'hFFFF_FFFC;
            rv.len      = $urandom_range(0, 15);
            rv.wmode    = 2;
            rv.err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rv.len)) : -1;
            rv.bresp    = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
            r           = $urandom_range(0, 7);
            rv.rl_mode  = (r == 0 && rv.len > 0) ? int'($urandom_range(0, rv.len - 1)) :
                          (r == 1) ? -2 : -1;
            rv.b2b      = 1'b0;
            rv.base     = $urandom;
            rv          = model(rv);
            run_txn(rv, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
